// File: rtl/fnd_scan_controller_pkg.sv
// Shared definitions for the FND scan controller: segment constants,
// nibble-to-segment decode and the converter FSM state type.
package fnd_pkg;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} conv_state_e;

  // Active-low {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex2seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/fnd_scan_controller_if.sv
// Host-side bus of the FND scan controller.
//   bin/load       : value to display and its capture strobe
//   dp_mask        : per-digit decimal point enables (live)
//   blank_lz       : leading-zero blanking enable (live)
//   busy/overflow  : conversion status
//   seg/seg_com    : active-low segment and digit-common pins
interface fnd_scan_controller_if #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned BIN_W  = 14
);
  logic [BIN_W-1:0]  bin;
  logic              load;
  logic [DIGITS-1:0] dp_mask;
  logic              blank_lz;
  logic              busy;
  logic              overflow;
  logic [7:0]        seg;
  logic [DIGITS-1:0] seg_com;

  modport master (
    output bin, load, dp_mask, blank_lz,
    input  busy, overflow, seg, seg_com
  );

  modport slave (
    input  bin, load, dp_mask, blank_lz,
    output busy, overflow, seg, seg_com
  );
endinterface

// File: rtl/fnd_scan_controller_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
//   clk, rst : clock, synchronous active-low reset
//   bin/load : value and single-cycle capture strobe (ignored while busy)
//   busy     : conversion in progress
//   bcd      : committed BCD, DIGITS nibbles
//   overflow : committed value did not fit in DIGITS nibbles
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int unsigned BIN_W  = 14,
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BIN_W-1:0]    bin,
  input  logic                load,
  output logic                busy,
  output logic [4*DIGITS-1:0] bcd,
  output logic                overflow
);

  localparam int unsigned BCD_W = 4*DIGITS + 4;
  localparam int unsigned CNT_W = $clog2(BIN_W + 1);

  conv_state_e      state, state_next;
  logic [BIN_W-1:0] sh_bin;
  logic [BCD_W-1:0] sh_bcd;
  logic [BCD_W-1:0] adj;
  logic [CNT_W-1:0] iter;
  logic             lost;
  logic             accept;

  // busy is a registered copy of "not idle", so it trails the FSM by one
  // cycle; gating on it as well keeps load ignored for the whole busy window.
  assign accept = load && !busy;

  always_comb begin
    adj = sh_bcd;
    for (int unsigned n = 0; n < DIGITS + 1; n++) begin
      if (sh_bcd[n*4 +: 4] >= 4'd5) adj[n*4 +: 4] = sh_bcd[n*4 +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = SHIFT;
      SHIFT:   if (iter == CNT_W'(BIN_W - 1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sh_bin   <= '0;
      sh_bcd   <= '0;
      iter     <= '0;
      lost     <= 1'b0;
      bcd      <= '0;
      overflow <= 1'b0;
      busy     <= 1'b0;
    end else begin
      busy <= (state != IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            sh_bin <= bin;
            sh_bcd <= '0;
            iter   <= '0;
            lost   <= 1'b0;
          end
        end
        SHIFT: begin
          sh_bcd <= {adj[BCD_W-2:0], sh_bin[BIN_W-1]};
          sh_bin <= sh_bin << 1;
          iter   <= iter + 1'b1;
          // Catches carries past the guard nibble for wide BIN_W.
          lost   <= lost | adj[BCD_W-1];
        end
        COMMIT: begin
          bcd      <= sh_bcd[4*DIGITS-1:0];
          overflow <= lost | (sh_bcd[BCD_W-1 -: 4] != 4'd0);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Multiplexed common-anode seven-segment driver with sequential BCD
// conversion, decimal points, leading-zero blanking and overflow dashes.
//   clk, rst : clock, synchronous active-low reset
//   bus      : fnd_scan_controller_if slave (bin, load, dp_mask, blank_lz,
//              busy, overflow, seg, seg_com)
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 100_000_000,
  parameter int unsigned SCAN_HZ = 1000,
  parameter int unsigned DIGITS  = 4,
  parameter int unsigned BIN_W   = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  fnd_scan_controller_if.slave bus
);

  localparam int unsigned DIV   = CLK_HZ / SCAN_HZ;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]    div_cnt;
  logic                tick;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] disp;
  logic [DIGITS-1:0]   zero_from;
  logic                acc;
  logic [3:0]          nib;
  logic                lead_zero;
  logic [7:0]          seg_next;

  bin2bcd_seq #(
    .BIN_W  (BIN_W),
    .DIGITS (DIGITS)
  ) u_conv (
    .clk      (clk),
    .rst      (rst),
    .bin      (bus.bin),
    .load     (bus.load),
    .busy     (bus.busy),
    .bcd      (disp),
    .overflow (bus.overflow)
  );

  assign tick = (div_cnt == CNT_W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (tick) idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
    end
  end

  // zero_from[i]: every nibble from i upwards is zero.
  always_comb begin
    zero_from = '0;
    acc       = 1'b1;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      acc = acc & (disp[(DIGITS-1-k)*4 +: 4] == 4'd0);
      zero_from[DIGITS-1-k] = acc;
    end
    nib       = '0;
    lead_zero = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        nib       = disp[i*4 +: 4];
        lead_zero = (i != 0) && zero_from[i];
      end
    end
    seg_next = {~bus.dp_mask[idx], hex2seg(nib)};
    if (bus.overflow)                    seg_next[6:0] = SEG_DASH[6:0];
    else if (bus.blank_lz && lead_zero)  seg_next[6:0] = SEG_BLANK[6:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bus.seg     <= SEG_BLANK;
      bus.seg_com <= '1;
    end else begin
      bus.seg     <= seg_next;
      bus.seg_com <= ~(DIGITS'(1) << idx);
    end
  end

endmodule

// File: doc/fnd_scan_controller.md
# fnd_scan_controller

Parametrised successor to the fixed 4-digit seven-segment driver. It accepts a binary value on a load strobe and converts it to BCD with a sequential double-dabble engine, so there is no combinational divide/modulo. The result is committed atomically to a display register and scanned across `DIGITS` common-anode digits using a clock-enable tick rather than a derived clock. Decimal points, leading-zero blanking and overflow indication are included; the block sits between datapath counters and the board FND pins.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `SCAN_HZ`, 1000: digit-advance rate. `DIV = CLK_HZ/SCAN_HZ` must be ≥ 2.
- `DIGITS`, 4: number of digits, 1..8.
- `BIN_W`, 14: width of the binary input.
- `clk`  input  1  system clock; all logic on the rising edge.
- `rst`  input  1  reset, synchronous, active-low.
- `bin`  input  BIN_W  unsigned value to display.
- `load`  input  1  single-cycle strobe that captures `bin`.
- `dp_mask`  input  DIGITS  bit i=1 lights the decimal point of digit i; sampled live.
- `blank_lz`  input  1  1 = blank leading zeros; sampled live.
- `busy`  output  1  conversion in progress.
- `overflow`  output  1  committed value ≥ 10^DIGITS.
- `seg`  output  8  active-low segments; `seg[7]` is the DP.
- `seg_com`  output  DIGITS  active-low one-hot digit enable.

## Operation
- Converter FSM states:
  - IDLE: on `load`=1, capture `bin`, clear the BCD shift register, go to SHIFT.
  - SHIFT: BIN_W iterations. Each iteration adds 3 to every BCD nibble ≥ 5, then shifts left one bit, taking in the binary MSB. When the iteration count reaches BIN_W, go to COMMIT.
  - COMMIT: copy the BCD to the display register and set `overflow` if any carry beyond DIGITS nibbles was produced. Return to IDLE.
- BCD register width is `4*DIGITS+4`. The extra nibble is used only for overflow detection.
- `load` while `busy`=1 is ignored. No queueing.
- Scan divider: counter 0..DIV-1; `tick` is asserted for one cycle at DIV-1. On `tick`, digit index `idx` increments and wraps from DIGITS-1 to 0.
- Digit drive:
  - `seg_com = ~(1<<idx)`.
  - `seg[6:0]` comes from the hex-to-seg function of display nibble `idx` (0→C0 … 9→90 in {dp,g..a} encoding).
  - `seg[7] = ~dp_mask[idx]`.
- Leading-zero blanking: when `blank_lz`=1, digit i > 0 shows 7'h7F if all nibbles ≥ i are zero. Digit 0 is never blanked. The DP is still honoured on blanked digits.
- Overflow: every digit shows dash (`seg[6:0]`=7'h3F) and the DP is still honoured. Overflow is cleared by the next COMMIT of an in-range value.

## Timing
- Reset (`rst`=0 at a clock edge): FSM→IDLE, `busy`=0, `overflow`=0, display register=0, `idx`=0, divider=0, `seg`=8'hFF, `seg_com`=all ones.
- `seg` and `seg_com` are registered. They reflect `idx` and the display register one cycle later, so the first cycle after reset release shows digit 0 = "0".
- Conversion latency: with `load` sampled at edge k, `busy`=1 from k+1 through k+BIN_W+1. The display register and `overflow` update at edge k+BIN_W+1, and `busy`=0 at k+BIN_W+2.
- The display changes only on COMMIT and never shows partial BCD.
- Reset asserted mid-conversion aborts the conversion. The old display is lost and reset values apply.
- A COMMIT coinciding with `tick` takes effect on the new `idx` in the same registered update.

## Structure
- Package `fnd_pkg`:
  - `SEG_BLANK`=8'hFF and `SEG_DASH`=8'hBF.
  - function `hex2seg(logic [3:0]) → logic [6:0]`.
  - FSM state enum {IDLE, SHIFT, COMMIT}.
- Sub-module `bin2bcd_seq` with parameters BIN_W and DIGITS. It contains the FSM, `busy`, the BCD output and the overflow flag.
- The top level contains the scan divider, `idx` counter, digit mux, blanking logic and output registers.

## Test plan
All scenarios use CLK_HZ=1000, SCAN_HZ=250 (DIV=4), DIGITS=4, BIN_W=14.
- Reset, then 20 cycles with no load → `seg_com` cycles E,D,B,7 every 4 cycles; `seg`=C0 on every digit; `busy`=0.
- `load` with `bin`=1234 → `busy` high exactly 15 cycles; then digits 3..0 show F9,A4,B0,99; `overflow`=0.
- `bin`=7, `blank_lz`=1, `dp_mask`=4'b0100 → digit0=F8, digit1=FF, digit2=7F, digit3=FF.
- `bin`=12000 → `overflow`=1 and all digits BF. Then load 9999 → `overflow`=0 and all digits 90.
- `load` of 5555 at cycle 3 of a conversion of 42 → pulse ignored; display shows 42; `busy` not extended.
- `rst`=0 asserted at cycle 7 of a conversion of 1234 → next cycle `busy`=0, `seg`=FF, `seg_com`=F; after release the display shows 0000.
